// File: rtl/lsu_req_if.sv
// Data-RAM bus between the load/store request issuer (master) and the data memory (slave).
// SRAM-style split handshake: address phase ends on data_addr_ok, data phase on data_data_ok.
interface lsu_req_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/lsu_req.sv
// Data-side request issuer: forms the data-RAM request from EX, runs the addr/data handshake,
// stalls the front pipe meanwhile and hands the raw read word plus lane select to MEM2.
// Optional macro LSU_MISALIGN_CHECK_EN: reject misaligned half/word accesses and flag them.
//
// Handshake: data_req is held with stable fields from REQ until data_addr_ok; the transaction
// then completes on the first data_data_ok seen in WAIT. data_data_ok outside WAIT is ignored.
// resp_valid is a one-cycle strobe issued only when downstream_stall is low.
module lsu_req (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [5:0]       lsu_op,
  input  logic [31:0]      ex_addr,
  input  logic [31:0]      ex_wdata,
  input  logic             downstream_stall,
  lsu_req_if.master        bus,
  output logic [3:0]       data_ram_sel,
  output logic [31:0]      rdata,
  output logic             resp_valid,
  output logic             stallreq,
  output logic             misalign,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;
  logic [31:0] r_buf;

  logic        w_en;
  logic        w_we;
  logic [2:0]  w_size_sel;
  logic        w_unused_sign;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic        w_req_seen;
  logic        w_accept;
  logic        w_done;

  // lsu_op = {en, we, size_sel[2:0], unsigned}; sign handling belongs to MEM2.
  assign w_en          = lsu_op[5];
  assign w_we          = lsu_op[4];
  assign w_size_sel    = lsu_op[3:1];
  assign w_unused_sign = lsu_op[0];

  always_comb begin
    w_size = 2'd0;
    if (w_size_sel[2])      w_size = 2'd2;
    else if (w_size_sel[1]) w_size = 2'd1;
  end

  assign w_req_seen = !rst && (r_state == S_IDLE) && ex_valid && w_en;

`ifdef LSU_MISALIGN_CHECK_EN
  logic w_misaligned;
  assign w_misaligned = ((w_size == 2'd1) && ex_addr[0]) ||
                        ((w_size == 2'd2) && (ex_addr[1:0] != 2'b00));
  assign w_addr   = ex_addr;
  assign w_accept = w_req_seen && !w_misaligned;
  assign misalign = w_req_seen && w_misaligned;
`else
  // Without checking, the address is forced onto its natural boundary.
  always_comb begin
    w_addr = ex_addr;
    if (w_size == 2'd1)      w_addr[0]   = 1'b0;
    else if (w_size == 2'd2) w_addr[1:0] = 2'b00;
  end
  assign w_accept = w_req_seen;
  assign misalign = 1'b0;
`endif

  always_comb begin
    w_sel   = 4'b1111;
    w_wdata = ex_wdata;
    case (w_size)
      2'd0: begin
        w_sel   = 4'b0001 << w_addr[1:0];
        w_wdata = {4{ex_wdata[7:0]}};
      end
      2'd1: begin
        w_sel   = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{ex_wdata[15:0]}};
      end
      default: begin
        w_sel   = 4'b1111;
        w_wdata = ex_wdata;
      end
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (w_accept)          w_state_nx = S_REQ;
      S_REQ:  if (bus.data_addr_ok)  w_state_nx = S_WAIT;
      S_WAIT: if (bus.data_data_ok)  w_state_nx = downstream_stall ? S_HOLD : S_IDLE;
      S_HOLD: if (!downstream_stall) w_state_nx = S_IDLE;
      default:                       w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wstrb <= 4'd0;
      r_wdata <= 32'd0;
      r_sel   <= 4'd0;
      r_buf   <= 32'd0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_wr    <= w_we;
        r_size  <= w_size;
        r_addr  <= w_addr;
        r_wstrb <= w_we ? w_sel : 4'd0;
        r_wdata <= w_wdata;
        r_sel   <= w_sel;
      end
      if ((r_state == S_WAIT) && bus.data_data_ok && downstream_stall)
        r_buf <= bus.data_rdata;
    end
  end

  assign w_done = !rst && !downstream_stall &&
                  (((r_state == S_WAIT) && bus.data_data_ok) || (r_state == S_HOLD));

  assign bus.data_req   = (r_state == S_REQ);
  assign bus.data_wr    = r_wr;
  assign bus.data_size  = r_size;
  assign bus.data_addr  = r_addr;
  assign bus.data_wstrb = r_wstrb;
  assign bus.data_wdata = r_wdata;

  assign data_ram_sel = r_sel;
  // In WAIT the bus word flows straight through; HOLD (and idle) present the buffer.
  assign rdata        = (r_state == S_WAIT) ? bus.data_rdata : r_buf;
  assign resp_valid   = w_done;
  assign stallreq     = w_accept || (!rst && ((r_state == S_REQ) || (r_state == S_WAIT)));
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_lsu_req.sv
// Directed bench for lsu_req: each step drives inputs 2ns after the rising edge and
// checks outputs 1ns later, well clear of the next edge.
module tb_lsu_req;
  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [5:0]  lsu_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        downstream_stall;
  logic [3:0]  data_ram_sel;
  logic [31:0] rdata;
  logic        resp_valid;
  logic        stallreq;
  logic        misalign;
  logic [1:0]  o_dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [5:0] OP_SB = 6'b110010;
  localparam logic [5:0] OP_SH = 6'b110100;
  localparam logic [5:0] OP_LH = 6'b100100;
  localparam logic [5:0] OP_LW = 6'b101000;

  lsu_req_if bus ();

  lsu_req dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .lsu_op           (lsu_op),
    .ex_addr          (ex_addr),
    .ex_wdata         (ex_wdata),
    .downstream_stall (downstream_stall),
    .bus              (bus.master),
    .data_ram_sel     (data_ram_sel),
    .rdata            (rdata),
    .resp_valid       (resp_valid),
    .stallreq         (stallreq),
    .misalign         (misalign),
    .o_dbg_state      (o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    downstream_stall = 1'b0;
  endtask

  // One accept cycle; returns after the combinational checks of that cycle.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
    tick();
    idle_inputs();
    ex_valid = 1'b1;
    lsu_op   = op;
    ex_addr  = addr;
    ex_wdata = wd;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    lsu_op = 6'd0;
    ex_addr = 32'd0;
    ex_wdata = 32'd0;
    bus.data_rdata = 32'd0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk("rst_state", {30'd0, o_dbg_state}, 32'd0);
    chk("rst_req", {31'd0, bus.data_req}, 32'd0);
    chk("rst_wr", {31'd0, bus.data_wr}, 32'd0);
    chk("rst_wstrb", {28'd0, bus.data_wstrb}, 32'd0);
    chk("rst_addr", bus.data_addr, 32'd0);
    chk("rst_wdata", bus.data_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_sel", {28'd0, data_ram_sel}, 32'd0);
    chk("rst_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_stall", {31'd0, stallreq}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);

    // Store byte at 0x1003, immediate handshake
    issue(OP_SB, 32'h0000_1003, 32'h0000_00AB);
    chk("sb_accept_stall", {31'd0, stallreq}, 32'd1);
    chk("sb_accept_req", {31'd0, bus.data_req}, 32'd0);
    tick(); idle_inputs(); bus.data_addr_ok = 1'b1; #1;
    chk("sb_req", {31'd0, bus.data_req}, 32'd1);
    chk("sb_wr", {31'd0, bus.data_wr}, 32'd1);
    chk("sb_size", {30'd0, bus.data_size}, 32'd0);
    chk("sb_addr", bus.data_addr, 32'h0000_1003);
    chk("sb_wstrb", {28'd0, bus.data_wstrb}, 32'h8);
    chk("sb_wdata", bus.data_wdata, 32'hABAB_ABAB);
    chk("sb_resp_early", {31'd0, resp_valid}, 32'd0);
    tick(); idle_inputs(); bus.data_data_ok = 1'b1; #1;
    chk("sb_resp", {31'd0, resp_valid}, 32'd1);
    chk("sb_wait_stall", {31'd0, stallreq}, 32'd1);
    chk("sb_wait_req", {31'd0, bus.data_req}, 32'd0);
    tick(); idle_inputs(); #1;
    chk("sb_after_resp", {31'd0, resp_valid}, 32'd0);
    chk("sb_after_stall", {31'd0, stallreq}, 32'd0);
    chk("sb_after_state", {30'd0, o_dbg_state}, 32'd0);

    // Store half at 0x10
    issue(OP_SH, 32'h0000_0010, 32'h1234_BEEF);
    tick(); idle_inputs(); bus.data_addr_ok = 1'b1; #1;
    chk("sh_size", {30'd0, bus.data_size}, 32'd1);
    chk("sh_wstrb", {28'd0, bus.data_wstrb}, 32'h3);
    chk("sh_wdata", bus.data_wdata, 32'hBEEF_BEEF);
    tick(); idle_inputs(); bus.data_data_ok = 1'b1; #1;
    chk("sh_resp", {31'd0, resp_valid}, 32'd1);

    // Load half at 0x2002
    issue(OP_LH, 32'h0000_2002, 32'hFFFF_FFFF);
    tick(); idle_inputs(); bus.data_addr_ok = 1'b1; #1;
    chk("lh_sel", {28'd0, data_ram_sel}, 32'hC);
    chk("lh_wstrb", {28'd0, bus.data_wstrb}, 32'h0);
    chk("lh_wr", {31'd0, bus.data_wr}, 32'd0);
    chk("lh_size", {30'd0, bus.data_size}, 32'd1);
    tick(); idle_inputs(); bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678; #1;
    chk("lh_resp", {31'd0, resp_valid}, 32'd1);
    chk("lh_rdata", rdata, 32'h1234_5678);

    // Load word with addr_ok three cycles late: request held for four cycles
    issue(OP_LW, 32'h0000_4000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(); idle_inputs(); bus.data_addr_ok = (i == 3); #1;
      chk("lw_hold_req", {31'd0, bus.data_req}, 32'd1);
      chk("lw_hold_addr", bus.data_addr, 32'h0000_4000);
      chk("lw_hold_stall", {31'd0, stallreq}, 32'd1);
    end
    tick(); idle_inputs(); bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D; #1;
    chk("lw_resp", {31'd0, resp_valid}, 32'd1);
    chk("lw_rdata", rdata, 32'hCAFE_F00D);
    chk("lw_resp_stall", {31'd0, stallreq}, 32'd1);
    tick(); idle_inputs(); #1;
    chk("lw_after_stall", {31'd0, stallreq}, 32'd0);

    // Downstream stall at data_ok: HOLD keeps original word
    issue(OP_LW, 32'h0000_5004, 32'h0);
    tick(); idle_inputs(); bus.data_addr_ok = 1'b1; #1;
    tick(); idle_inputs(); bus.data_data_ok = 1'b1; downstream_stall = 1'b1;
    bus.data_rdata = 32'hDEAD_BEEF; #1;
    chk("hold_no_resp", {31'd0, resp_valid}, 32'd0);
    tick(); idle_inputs(); downstream_stall = 1'b1; bus.data_rdata = 32'h1111_1111; #1;
    chk("hold_state", {30'd0, o_dbg_state}, 32'd3);
    chk("hold_no_resp2", {31'd0, resp_valid}, 32'd0);
    chk("hold_stallreq", {31'd0, stallreq}, 32'd0);
    chk("hold_rdata", rdata, 32'hDEAD_BEEF);
    tick(); idle_inputs(); bus.data_rdata = 32'h2222_2222; #1;
    chk("hold_resp", {31'd0, resp_valid}, 32'd1);
    chk("hold_rdata_out", rdata, 32'hDEAD_BEEF);
    tick(); idle_inputs(); #1;
    chk("hold_after_state", {30'd0, o_dbg_state}, 32'd0);
    chk("hold_after_resp", {31'd0, resp_valid}, 32'd0);

    // addr_ok and data_ok together in REQ; a new EX op must not disturb the request
    issue(OP_LW, 32'h0000_6000, 32'h0);
    tick(); idle_inputs(); ex_valid = 1'b1; ex_addr = 32'h0000_7000;
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; #1;
    chk("both_ok_resp", {31'd0, resp_valid}, 32'd0);
    chk("both_ok_addr", bus.data_addr, 32'h0000_6000);
    tick(); idle_inputs(); #1;
    chk("both_ok_state", {30'd0, o_dbg_state}, 32'd2);
    chk("both_ok_resp2", {31'd0, resp_valid}, 32'd0);
    tick(); idle_inputs(); bus.data_data_ok = 1'b1; bus.data_rdata = 32'hA5A5_A5A5; #1;
    chk("both_ok_done", {31'd0, resp_valid}, 32'd1);
    chk("both_ok_rdata", rdata, 32'hA5A5_A5A5);

    // Reset in WAIT followed by a late data_ok
    issue(OP_LW, 32'h0000_8000, 32'h0);
    tick(); idle_inputs(); bus.data_addr_ok = 1'b1; #1;
    tick(); idle_inputs(); rst = 1'b1; #1;
    tick(); idle_inputs(); rst = 1'b0; bus.data_data_ok = 1'b1; #1;
    chk("rstmid_state", {30'd0, o_dbg_state}, 32'd0);
    chk("rstmid_resp", {31'd0, resp_valid}, 32'd0);
    chk("rstmid_req", {31'd0, bus.data_req}, 32'd0);
    chk("rstmid_stall", {31'd0, stallreq}, 32'd0);
    tick(); idle_inputs(); #1;
    chk("rstmid_state2", {30'd0, o_dbg_state}, 32'd0);

    // Word load at 0x3002
    issue(OP_LW, 32'h0000_3002, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_stall", {31'd0, stallreq}, 32'd0);
    tick(); idle_inputs(); #1;
    chk("mis_flag_pulse", {31'd0, misalign}, 32'd0);
    chk("mis_req", {31'd0, bus.data_req}, 32'd0);
    chk("mis_state", {30'd0, o_dbg_state}, 32'd0);
`else
    chk("mis_flag", {31'd0, misalign}, 32'd0);
    chk("mis_stall", {31'd0, stallreq}, 32'd1);
    tick(); idle_inputs(); bus.data_addr_ok = 1'b1; #1;
    chk("mis_req", {31'd0, bus.data_req}, 32'd1);
    chk("mis_addr", bus.data_addr, 32'h0000_3000);
    chk("mis_sel", {28'd0, data_ram_sel}, 32'hF);
    tick(); idle_inputs(); bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0BAD_CAFE; #1;
    chk("mis_resp", {31'd0, resp_valid}, 32'd1);
`endif

    tick(); idle_inputs(); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_req.md
# lsu_req

Data-side request issuer for the load/store path. It takes the decoded memory op and address from EX, forms the SRAM-style data-bus request, and runs the address/data handshake. It raises a pipeline stall request until the bus responds, then hands the raw read word and byte-select to MEM2, which performs load extraction. It is the requesting end of the data-RAM interface whose response side MEM2 consumes.

## Interface
Parameters:
- none (widths fixed by `define.vh`: `LSU_WD` = 6).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX holds a valid instruction this cycle.
- lsu_op  in  `LSU_WD`  {en, we, size_sel[2:0] one-hot (b,h,w at bits 0,1,2), unsigned}.
- ex_addr  in  32  effective address.
- ex_wdata  in  32  store data, right-aligned.
- downstream_stall  in  1  MEM2/WB cannot take a result this cycle.
- data_req  out  1  bus request valid.
- data_wr  out  1  1 = store.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  request address.
- data_wstrb  out  4  byte write strobes; 0 for loads.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  address phase accepted.
- data_data_ok  in  1  data phase complete; data_rdata valid.
- data_rdata  in  32  read word.
- data_ram_sel  out  4  byte-lane select passed to MEM2.
- rdata  out  32  read word passed to MEM2.
- resp_valid  out  1  one-cycle completion strobe.
- stallreq  out  1  freeze IF..EX.
- misalign  out  1  misaligned-access flag (see Configuration).

## Operation
- Accept: IDLE & ex_valid & lsu_op.en (& aligned when checking is on). Registers we, size, addr, wstrb, wdata, sel. Next state is REQ.
- Lane rules (addr[1:0] = a):
  - byte: sel = 1<<a; wdata = {4{ex_wdata[7:0]}}.
  - half: sel = a[1] ? 4'b1100 : 4'b0011; wdata = {2{ex_wdata[15:0]}}.
  - word: sel = 4'b1111; wdata = ex_wdata.
  - data_wstrb = we ? sel : 0.
- FSM:
  - IDLE: waits for accept.
  - REQ: data_req = 1; on data_addr_ok go to WAIT.
  - WAIT: on data_data_ok, if downstream_stall go to HOLD and latch data_rdata, else go to IDLE with resp_valid = 1 and rdata = data_rdata (combinational pass).
  - HOLD: rdata = latched buffer; when !downstream_stall, resp_valid = 1 and go to IDLE.
- Request fields stay stable from REQ until addr_ok. data_ok in IDLE/REQ is ignored.
- stallreq = accept | REQ | WAIT. It is low in HOLD, where downstream_stall already freezes the pipe.
- Stores complete on data_data_ok like loads; rdata is don't-care for stores.

## Timing
- Reset values: data_req, data_wr, data_wstrb, resp_valid, stallreq, misalign = 0; data_addr, data_wdata, rdata, data_ram_sel = 0; state = IDLE.
- Latency:
  - Accept at cycle T gives data_req at T+1.
  - Minimum completion, with addr_ok at T+1 and data_ok at T+2, gives resp_valid at T+2.
- addr_ok and data_ok in the same cycle while in REQ: only addr_ok is honoured, and the transition is to WAIT.
- rst asserted mid-transaction: IDLE next cycle; data_req drops; any late data_ok is ignored.
- No new accept while state ≠ IDLE (one outstanding transaction).

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - Misaligned accesses are half with a[0] = 1, or word with a ≠ 0.
  - Such an access makes no request and does not assert stallreq.
  - misalign pulses for 1 cycle (the accept cycle).
- LSU_MISALIGN_CHECK_EN undefined:
  - misalign is tied 0.
  - data_addr low bits are cleared to size alignment (half: bit 0; word: bits 1:0).
  - Lanes are computed from the cleared address.

## Test plan
- Store byte, addr 0x1003, wdata 0xAB, addr_ok/data_ok immediate -> data_wstrb 4'b1000, data_wdata 0xABABABAB, data_size 0, resp_valid at T+2.
- Load half, addr 0x2002, data_rdata 0x1234_5678 -> data_ram_sel 4'b1100, data_wstrb 0, rdata 0x12345678 with resp_valid.
- Load word, addr_ok delayed 3 cycles -> data_req and data_addr held steady 4 cycles, stallreq high throughout, low after resp_valid.
- Load with downstream_stall high for 2 cycles at data_ok, and data_rdata changing afterwards -> HOLD keeps the original word; resp_valid on the cycle stall drops.
- rst in WAIT, then a spurious data_ok -> no resp_valid, data_req 0, state IDLE.
- Word load at 0x3002 -> with macro: misalign = 1, data_req stays 0; without: data_addr 0x3000, data_ram_sel 4'b1111.
